// File: rtl/freq_synth.sv
// Fractional-N square-wave generator. Fxout is registered and updates one Clk after the accumulator wraps.
// Freq_Ready drops while a new frequency waits for the low phase (PEND) and while stopping (STOP).
module freq_synth #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned WIDTH    = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Enable,
  input  logic [WIDTH-1:0] Freq_In,
  input  logic             Freq_Valid,
  output logic             Freq_Ready,
  output logic             Fxout,
  output logic             Active,
  output logic [WIDTH-1:0] Cycle_Count
);

  localparam int unsigned      AW   = WIDTH + 2;
  localparam logic [AW-1:0]    MOD  = AW'(CLK_FREQ);
  localparam logic [WIDTH-1:0] HALF = WIDTH'(CLK_FREQ / 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] freq_q, freq_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             fx_q, fx_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             clr_cnt;
  logic [WIDTH-1:0] freq_clamped;
  logic [AW-1:0]    step;
  logic [AW-1:0]    acc_sum;
  logic [AW-1:0]    acc_adv;
  logic             wrap;

  assign Freq_Ready   = (state_q == S_IDLE) || (state_q == S_RUN);
  assign Active       = (state_q != S_IDLE);
  assign Fxout        = fx_q;
  assign Cycle_Count  = cnt_q;

  assign accept       = Freq_Valid && Freq_Ready;
  assign freq_clamped = (Freq_In > HALF) ? HALF : Freq_In;

  // Two toggles per output period, so the phase step is twice the frequency.
  assign step    = {1'b0, freq_q, 1'b0};
  assign acc_sum = acc_q + step;
  assign wrap    = (acc_sum >= MOD);
  assign acc_adv = wrap ? (acc_sum - MOD) : acc_sum;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    freq_d  = freq_q;
    pend_d  = pend_q;
    fx_d    = fx_q;
    clr_cnt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          freq_d  = freq_clamped;
          acc_d   = '0;
          clr_cnt = 1'b1;
          if (Enable) state_d = S_RUN;
        end else if (Enable && (freq_q != '0)) begin
          acc_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_adv;
        fx_d  = fx_q ^ wrap;
        if (accept) begin
          pend_d  = freq_clamped;
          state_d = S_PEND;
        end else if (!Enable) begin
          state_d = S_STOP;
        end
      end
      S_PEND: begin
        // Switch only at a low phase so the new waveform starts without a runt pulse.
        if (!fx_q || wrap) begin
          fx_d    = 1'b0;
          freq_d  = pend_q;
          acc_d   = '0;
          clr_cnt = 1'b1;
          state_d = Enable ? S_RUN : S_STOP;
        end else if (!Enable) begin
          freq_d  = pend_q;
          acc_d   = '0;
          clr_cnt = 1'b1;
          state_d = S_STOP;
        end else begin
          acc_d = acc_adv;
        end
      end
      S_STOP: begin
        if (!fx_q || wrap) begin
          fx_d    = 1'b0;
          acc_d   = '0;
          state_d = S_IDLE;
        end else begin
          acc_d = acc_adv;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clr_cnt)
      cnt_d = '0;
    else if (!fx_q && fx_d)
      cnt_d = cnt_q + 1'b1;
    else
      cnt_d = cnt_q;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      freq_q  <= '0;
      pend_q  <= '0;
      fx_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      freq_q  <= freq_d;
      pend_q  <= pend_d;
      fx_q    <= fx_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_freq_synth.sv
// Scoreboard bench for freq_synth: a toggle-count model (floor(n*2F/CLK)) predicts every cycle's outputs.
module tb_freq_synth;

  localparam int unsigned CF = 100;
  localparam int unsigned W  = 32;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PEND = 2;
  localparam int M_STOP = 3;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic         Enable;
  logic [W-1:0] Freq_In;
  logic         Freq_Valid;
  logic         Freq_Ready;
  logic         Fxout;
  logic         Active;
  logic [W-1:0] Cycle_Count;

  freq_synth #(.CLK_FREQ(CF), .WIDTH(W)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Enable      (Enable),
    .Freq_In     (Freq_In),
    .Freq_Valid  (Freq_Valid),
    .Freq_Ready  (Freq_Ready),
    .Fxout       (Fxout),
    .Active      (Active),
    .Cycle_Count (Cycle_Count)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic         fx;
    logic         act;
    logic         rdy;
    logic [W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: phase expressed as cycles since the waveform restarted from acc=0.
  int      m_st;
  longint  m_F, m_pend, m_n, m_cnt;
  bit      m_fx;

  function automatic longint toggles(longint n, longint f);
    return (n * 2 * f) / CF;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_F = 0; m_pend = 0; m_n = 0; m_cnt = 0; m_fx = 1'b0;
  endtask

  task automatic model_edge(bit en, bit vld, longint fin);
    bit     rdy, acc, tog, nfx;
    longint cl;
    rdy = (m_st == M_IDLE) || (m_st == M_RUN);
    acc = rdy && vld;
    cl  = (fin > CF / 2) ? CF / 2 : fin;
    tog = (m_st != M_IDLE) && (toggles(m_n + 1, m_F) != toggles(m_n, m_F));
    nfx = m_fx;
    case (m_st)
      M_IDLE: begin
        if (acc) begin
          m_F = cl; m_n = 0; m_cnt = 0;
          if (en) m_st = M_RUN;
        end else if (en && m_F != 0) begin
          m_n = 0; m_st = M_RUN;
        end
      end
      M_RUN: begin
        nfx = m_fx ^ tog;
        m_n++;
        if (acc) begin
          m_pend = cl; m_st = M_PEND;
        end else if (!en) begin
          m_st = M_STOP;
        end
      end
      M_PEND: begin
        if (!m_fx || tog) begin
          nfx = 1'b0; m_F = m_pend; m_n = 0; m_cnt = 0;
          m_st = en ? M_RUN : M_STOP;
        end else if (!en) begin
          m_F = m_pend; m_n = 0; m_cnt = 0; m_st = M_STOP;
        end else begin
          m_n++;
        end
      end
      default: begin
        if (!m_fx || tog) begin
          nfx = 1'b0; m_n = 0; m_st = M_IDLE;
        end else begin
          m_n++;
        end
      end
    endcase
    if (!m_fx && nfx) m_cnt++;
    m_fx = nfx;
  endtask

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic cyc(bit en, bit vld, logic [W-1:0] fin);
    exp_t e;
    Enable     = en;
    Freq_Valid = vld;
    Freq_In    = fin;
    @(posedge Clk);
    model_edge(en, vld, longint'(fin));
    e.fx  = m_fx;
    e.act = (m_st != M_IDLE);
    e.rdy = (m_st == M_IDLE) || (m_st == M_RUN);
    e.cnt = m_cnt[W-1:0];
    sb.push_back(e);
    #1;
  endtask

  function automatic bit cond(int mode);
    case (mode)
      0:       return m_st == M_RUN;
      1:       return (m_st == M_RUN) && m_fx;
      default: return m_st == M_IDLE;
    endcase
  endfunction

  task automatic wait_cond(int mode, int lim, string name);
    bit ok;
    ok = cond(mode);
    for (int i = 0; i < lim && !ok; i++) begin
      cyc(Enable, 1'b0, '0);
      ok = cond(mode);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s timeout after %0d cycles got=0 expected=1", name, lim);
    end
  endtask

  // Monitor: every clock the DUT presents a waveform sample; compare it to the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("fxout",       Fxout,       e.fx);
        chk("active",      Active,      e.act);
        chk("freq_ready",  Freq_Ready,  e.rdy);
        chk("cycle_count", Cycle_Count, e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit en_r;
    Rst_n = 1'b0; Enable = 1'b0; Freq_Valid = 1'b0; Freq_In = '0;
    model_reset();
    #12;
    chk("rst_fxout", Fxout, 0);
    chk("rst_active", Active, 0);
    chk("rst_ready", Freq_Ready, 1);
    chk("rst_count", Cycle_Count, 0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;

    // 25 Hz: first rise two cycles into RUN, 250 rises per 1000 cycles.
    cyc(1, 1, 25);
    cyc(1, 0, '0);
    chk("t1_no_rise_yet", Fxout, 0);
    cyc(1, 0, '0);
    chk("t1_first_rise", Fxout, 1);
    for (int i = 0; i < 998; i++) cyc(1, 0, '0);
    chk("t1_count_250", Cycle_Count, 250);

    // 30 Hz: uneven half-periods, no drift.
    cyc(1, 1, 30);
    wait_cond(0, 50, "t2_reach_run");
    for (int i = 0; i < 1000; i++) cyc(1, 0, '0);
    chk("t2_count_range", (Cycle_Count >= 299 && Cycle_Count <= 301), 1);

    // 80 Hz clamps to 50: toggles every cycle.
    cyc(1, 1, 80);
    wait_cond(0, 50, "t3_reach_run");
    for (int i = 0; i < 1000; i++) cyc(1, 0, '0);
    chk("t3_count_500", Cycle_Count, 500);

    // Retune while high: held in PEND until the fall.
    cyc(1, 1, 25);
    wait_cond(0, 50, "t4_reach_run25");
    wait_cond(1, 50, "t4_reach_high");
    cyc(1, 1, 10);
    chk("t4_ready_low", Freq_Ready, 0);
    wait_cond(0, 50, "t4_reach_run10");
    chk("t4_count_cleared", Cycle_Count, 0);
    for (int i = 0; i < 40; i++) cyc(1, 0, '0);
    chk("t4_count_4", Cycle_Count, 4);

    // Drop Enable while high: finish the high phase, then idle.
    wait_cond(1, 50, "t5_reach_high");
    cyc(0, 0, '0);
    wait_cond(2, 50, "t5_reach_idle");
    chk("t5_idle_active", Active, 0);
    chk("t5_idle_fx", Fxout, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, '0);
    chk("t5_held_low", Fxout, 0);
    cyc(1, 0, '0);
    chk("t5_restart_active", Active, 1);
    for (int i = 0; i < 40; i++) cyc(1, 0, '0);

    // Asynchronous reset mid-high-phase.
    wait_cond(1, 50, "t6_reach_high");
    #2;
    Rst_n = 1'b0;
    sb.delete();
    model_reset();
    #1;
    chk("t6_async_fx", Fxout, 0);
    chk("t6_async_active", Active, 0);
    chk("t6_async_count", Cycle_Count, 0);
    chk("t6_async_ready", Freq_Ready, 1);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    cyc(1, 1, '0);
    for (int i = 0; i < 50; i++) cyc(1, 0, '0);
    chk("t6_zero_fx", Fxout, 0);
    chk("t6_zero_active", Active, 1);

    // Randomized retunes and enable changes.
    en_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) en_r = ~en_r;
      cyc(en_r, ($urandom_range(0, 19) == 0), W'($urandom_range(1, 70)));
    end

    @(negedge Clk); #1;
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
